mm_issue_sched: RTL and testbench
=================================

MM_ISSUE_SCHED -- requirements
Module: mm_issue_sched

Interface
REQ-001 Parameters: ADDR_W default 8, RAM address width; TAG_W default 4, command tag width; MUL_LAT default 24, cycles from multiplier operand to result; RD_LAT default 1, RAM read latency; QDEPTH default 4, command queue entries.
REQ-002 Ports, one clock; reset is asynchronous and active-high:
- clk  in  1  sole clock; multiplier and both RAMs share it.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue can accept.
- cmd_addr_a  in  ADDR_W  RAM0 operand address.
- cmd_addr_b  in  ADDR_W  RAM1 operand address.
- cmd_addr_z  in  ADDR_W  result address, written to both RAMs.
- cmd_tag  in  TAG_W  returned on completion.
- rd_addr0  out  ADDR_W  RAM0 port-B address.
- rd_addr1  out  ADDR_W  RAM1 port-B address.
- wr_en  out  1  port-A write enable, both RAMs.
- wr_addr  out  ADDR_W  port-A address, both RAMs.
- done_valid  out  1  one-cycle completion pulse.
- done_tag  out  TAG_W  tag of the completing command.
- busy  out  1  queue non-empty or any operation in flight.

Function
REQ-003 Command handshake: a command is accepted on a rising edge where cmd_valid and cmd_ready are both high; cmd_ready equals "queue not full", registered, with no same-cycle bypass.
REQ-004 Queue: in-order FIFO of QDEPTH entries {addr_a, addr_b, addr_z, tag}; pointers wrap modulo QDEPTH; a simultaneous accept and issue when full is impossible by REQ-003; when neither full nor empty, simultaneous accept and issue leave occupancy unchanged.
REQ-005 Issue: the head issues in cycle t when the queue is non-empty and no hazard exists (REQ-007); in that cycle rd_addr0 = addr_a and rd_addr1 = addr_b. At most one issue per cycle.
REQ-006 Pipeline tracker: P = RD_LAT + MUL_LAT stages, each stage holding {valid, addr_z, tag}. An operation issued at cycle t writes at cycle t+P: wr_en=1, wr_addr=addr_z, done_valid=1, done_tag=tag, all in the same cycle.
REQ-007 RAW hazard: the head stalls while its addr_a or addr_b equals the addr_z of any valid tracker entry, including the entry writing in the current cycle. The earliest dependent issue is therefore t_write+1.
REQ-008 No write-after-write check: writes occur in issue order; equal addr_z values in back-to-back commands are legal.
REQ-009 Command acceptance is stall-independent: the queue keeps accepting while the head is stalled.
REQ-010 When idle, rd_addr0, rd_addr1, and wr_addr hold their last values; wr_en=0; done_valid=0.
REQ-011 Latency: on an empty idle block, command accepted at edge t issues at t+1; done_valid at t+1+P.
REQ-012 Throughput: with no hazards, one issue per cycle; in steady state, one completion per cycle.
REQ-013 busy=0 if and only if the queue is empty and all tracker entries are invalid.

Reset
REQ-014 While rst is high: queue empty, all tracker entries invalid, cmd_ready=1, wr_en=0, done_valid=0, busy=0, address outputs 0, done_tag 0.
REQ-015 Reset mid-operation discards queued and in-flight commands: no write and no done pulse for them after reset deasserts; the first accept is possible at the first edge after deassertion.

Structure
REQ-016 Shared package mm_pkg holds: the default ADDR_W, TAG_W, MUL_LAT, and RD_LAT values; the cmd_t struct {addr_a, addr_b, addr_z, tag}; and the trk_t struct {valid, addr_z, tag}.
REQ-017 One sub-module, mm_cmd_fifo (parameterised synchronous FIFO of cmd_t). Tracker, hazard compare, and issue logic remain in mm_issue_sched.

Verification (MUL_LAT=24, RD_LAT=1, P=25)
REQ-018 Single command {a=3, b=5, z=7, tag=1} accepted at cycle 0:
- cycle 1: rd_addr0=3, rd_addr1=5.
- cycle 26: wr_en=1, wr_addr=7, done_tag=1.
- cycle 27: busy=0.
REQ-019 Four independent commands, z=10..13, accepted on consecutive cycles: done_valid high on 4 consecutive cycles in tag order; cmd_ready never drops.
REQ-020 RAW: {a=1, b=2, z=9} then {a=9, b=2, z=4}: the first issues at cycle 1 and writes at 26; the second issues at 27, never earlier, and writes at 52.
REQ-021 Full queue: hold the head stalled via a hazard and offer 6 commands; cmd_ready=0 after 4 accepts; it returns to 1 the cycle after the head issues; no command is lost or duplicated.
REQ-022 Assert rst at cycle 10 with 3 operations in flight and 2 queued: no wr_en or done_valid afterwards; busy=0 during reset; a new command completes with nominal latency.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and default sizing for the multiply-issue scheduler.
package mm_pkg;

  localparam int unsigned DEF_ADDR_W  = 8;
  localparam int unsigned DEF_TAG_W   = 4;
  localparam int unsigned DEF_MUL_LAT = 24;
  localparam int unsigned DEF_RD_LAT  = 1;
  localparam int unsigned DEF_QDEPTH  = 4;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr_a;
    logic [DEF_ADDR_W-1:0] addr_b;
    logic [DEF_ADDR_W-1:0] addr_z;
    logic [DEF_TAG_W-1:0]  tag;
  } cmd_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr_z;
    logic [DEF_TAG_W-1:0]  tag;
  } trk_t;

endpackage

// File: rtl/mm_cmd_fifo.sv
// In-order command queue; ready/empty flags are registered from the next count.
module mm_cmd_fifo
  import mm_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_QDEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  cmd_t data_i,
  input  logic pop_i,
  output cmd_t head_o,
  output logic empty_o,
  output logic ready_o,
  output logic empty_nxt_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, ready_q;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign push_ok = push_i && ready_q;
  assign pop_ok  = pop_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= (cnt_d == '0);
      ready_q  <= (32'(cnt_d) != DEPTH);
    end
  end

  // Storage needs no reset: entries are only read once the count says valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o      = mem_q[rd_ptr_q];
  assign empty_o     = empty_q;
  assign ready_o     = ready_q;
  assign empty_nxt_c = (cnt_d == '0);

endmodule

// File: rtl/mm_issue_sched.sv
// Issues queued multiply commands to two RAMs, tracking in-flight results
// to stall read-after-write dependencies until the producer has written.
module mm_issue_sched
  import mm_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned TAG_W   = DEF_TAG_W,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT,
  parameter int unsigned RD_LAT  = DEF_RD_LAT,
  parameter int unsigned QDEPTH  = DEF_QDEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [ADDR_W-1:0] cmd_addr_z,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              done_valid,
  output logic [TAG_W-1:0]  done_tag,
  output logic              busy
);

  localparam int unsigned P = RD_LAT + MUL_LAT;

  cmd_t cmd_in, head;
  logic fifo_empty, fifo_ready, fifo_empty_nxt;
  logic push, issue, hazard;

  trk_t trk_q [P];
  trk_t trk_d [P];

  logic [ADDR_W-1:0] rd_addr0_q, rd_addr0_d, rd_addr1_q, rd_addr1_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [TAG_W-1:0]  done_tag_q, done_tag_d;
  logic              wr_en_q, wr_en_d, done_valid_q, done_valid_d;
  logic              busy_q, busy_d;

  always_comb begin
    cmd_in.addr_a = DEF_ADDR_W'(cmd_addr_a);
    cmd_in.addr_b = DEF_ADDR_W'(cmd_addr_b);
    cmd_in.addr_z = DEF_ADDR_W'(cmd_addr_z);
    cmd_in.tag    = DEF_TAG_W'(cmd_tag);
  end

  assign push = cmd_valid && fifo_ready;

  mm_cmd_fifo #(
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .data_i     (cmd_in),
    .pop_i      (issue),
    .head_o     (head),
    .empty_o    (fifo_empty),
    .ready_o    (fifo_ready),
    .empty_nxt_c(fifo_empty_nxt)
  );

  // Last stage is the entry that writes in the cycle the head would issue,
  // so the full tracker is compared: dependents issue one cycle after the write.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < P; i++) begin
      if (trk_q[i].valid &&
          (trk_q[i].addr_z == head.addr_a || trk_q[i].addr_z == head.addr_b))
        hazard = 1'b1;
    end
  end

  assign issue = !fifo_empty && !hazard;

  always_comb begin
    trk_d[0] = '{valid: issue, addr_z: head.addr_z, tag: head.tag};
    for (int unsigned i = 1; i < P; i++) trk_d[i] = trk_q[i-1];

    rd_addr0_d   = rd_addr0_q;
    rd_addr1_d   = rd_addr1_q;
    wr_addr_d    = wr_addr_q;
    done_tag_d   = done_tag_q;
    wr_en_d      = trk_q[P-1].valid;
    done_valid_d = trk_q[P-1].valid;
    busy_d       = !fifo_empty_nxt || trk_q[P-1].valid;

    if (issue) begin
      rd_addr0_d = ADDR_W'(head.addr_a);
      rd_addr1_d = ADDR_W'(head.addr_b);
    end
    if (trk_q[P-1].valid) begin
      wr_addr_d  = ADDR_W'(trk_q[P-1].addr_z);
      done_tag_d = TAG_W'(trk_q[P-1].tag);
    end
    for (int unsigned i = 0; i < P; i++) begin
      if (trk_d[i].valid) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < P; i++) trk_q[i] <= '0;
      rd_addr0_q   <= '0;
      rd_addr1_q   <= '0;
      wr_addr_q    <= '0;
      done_tag_q   <= '0;
      wr_en_q      <= 1'b0;
      done_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < P; i++) trk_q[i] <= trk_d[i];
      rd_addr0_q   <= rd_addr0_d;
      rd_addr1_q   <= rd_addr1_d;
      wr_addr_q    <= wr_addr_d;
      done_tag_q   <= done_tag_d;
      wr_en_q      <= wr_en_d;
      done_valid_q <= done_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign cmd_ready  = fifo_ready;
  assign rd_addr0   = rd_addr0_q;
  assign rd_addr1   = rd_addr1_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign done_valid = done_valid_q;
  assign done_tag   = done_tag_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mm_issue_sched.sv
// Bench for mm_issue_sched: directed scenarios plus random traffic against a
// timing model that derives each command's issue and write cycle arithmetically.
module tb_mm_issue_sched;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned MUL_LAT = 24;
  localparam int unsigned RD_LAT  = 1;
  localparam int unsigned QDEPTH  = 4;
  localparam int          P       = int'(RD_LAT + MUL_LAT);

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr_a, cmd_addr_b, cmd_addr_z;
  logic [TAG_W-1:0]  cmd_tag;
  logic [ADDR_W-1:0] rd_addr0, rd_addr1, wr_addr;
  logic              wr_en, done_valid, busy;
  logic [TAG_W-1:0]  done_tag;

  mm_issue_sched #(
    .ADDR_W (ADDR_W),
    .TAG_W  (TAG_W),
    .MUL_LAT(MUL_LAT),
    .RD_LAT (RD_LAT),
    .QDEPTH (QDEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr_a(cmd_addr_a),
    .cmd_addr_b(cmd_addr_b),
    .cmd_addr_z(cmd_addr_z),
    .cmd_tag   (cmd_tag),
    .rd_addr0  (rd_addr0),
    .rd_addr1  (rd_addr1),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .done_valid(done_valid),
    .done_tag  (done_tag),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int z;
    int tag;
    int acc;  // edge at which the command was accepted
    int iss;  // cycle in which rd_addr shows the command
  } rec_t;

  rec_t recs[$];
  rec_t stim[$];
  int   cyc;
  int   checks;
  int   failures;
  int   last_rd0, last_rd1, last_wr, last_iss;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic rec_t mk(input int a, input int b, input int z, input int tag);
    rec_t r;
    r.a = a; r.b = b; r.z = z; r.tag = tag; r.acc = 0; r.iss = 0;
    return r;
  endfunction

  function automatic int occ(input int c);
    int n = 0;
    foreach (recs[i]) if (recs[i].acc <= c && recs[i].iss > c) n++;
    return n;
  endfunction

  function automatic bit m_busy(input int c);
    if (occ(c) != 0) return 1'b1;
    foreach (recs[i]) if (recs[i].iss <= c && c <= recs[i].iss + P) return 1'b1;
    return 1'b0;
  endfunction

  // Issue cycle: after acceptance, after the previous issue, and after every
  // earlier producer of either operand has written.
  function automatic int issue_cycle(input rec_t r);
    int t = r.acc + 1;
    if (last_iss + 1 > t) t = last_iss + 1;
    foreach (recs[j])
      if ((recs[j].z == r.a || recs[j].z == r.b) && recs[j].iss + P + 1 > t)
        t = recs[j].iss + P + 1;
    return t;
  endfunction

  task automatic one_cycle(input int unsigned prob);
    bit   exp_wr;
    int   wtag;
    bit   v;
    rec_t r;
    exp_wr = 1'b0;
    wtag   = 0;
    foreach (recs[i]) begin
      if (recs[i].iss == cyc) begin
        last_rd0 = recs[i].a;
        last_rd1 = recs[i].b;
      end
      if (recs[i].iss + P == cyc) begin
        exp_wr  = 1'b1;
        last_wr = recs[i].z;
        wtag    = recs[i].tag;
      end
    end
    check("cmd_ready", 32'(cmd_ready), 32'(occ(cyc) < int'(QDEPTH)));
    check("busy", 32'(busy), 32'(m_busy(cyc)));
    check("wr_en", 32'(wr_en), 32'(exp_wr));
    check("done_valid", 32'(done_valid), 32'(exp_wr));
    check("rd_addr0", 32'(rd_addr0), last_rd0);
    check("rd_addr1", 32'(rd_addr1), last_rd1);
    check("wr_addr", 32'(wr_addr), last_wr);
    if (exp_wr) check("done_tag", 32'(done_tag), wtag);

    v = (stim.size() != 0) && ($urandom_range(99) < prob);
    cmd_valid = v;
    if (v) begin
      cmd_addr_a = ADDR_W'(stim[0].a);
      cmd_addr_b = ADDR_W'(stim[0].b);
      cmd_addr_z = ADDR_W'(stim[0].z);
      cmd_tag    = TAG_W'(stim[0].tag);
    end else begin
      cmd_addr_a = ADDR_W'($urandom);
      cmd_addr_b = ADDR_W'($urandom);
      cmd_addr_z = ADDR_W'($urandom);
      cmd_tag    = TAG_W'($urandom);
    end
    if (v && occ(cyc) < int'(QDEPTH)) begin
      r        = stim.pop_front();
      r.acc    = cyc + 1;
      r.iss    = issue_cycle(r);
      last_iss = r.iss;
      recs.push_back(r);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    recs.delete();
    stim.delete();
    last_rd0 = 0; last_rd1 = 0; last_wr = 0; last_iss = -1000;
    #1;
    for (int i = 0; i < n; i++) begin
      check("rst_busy", 32'(busy), 0);
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_done_valid", 32'(done_valid), 0);
      check("rst_cmd_ready", 32'(cmd_ready), 1);
      check("rst_rd_addr0", 32'(rd_addr0), 0);
      check("rst_rd_addr1", 32'(rd_addr1), 0);
      check("rst_wr_addr", 32'(wr_addr), 0);
      check("rst_done_tag", 32'(done_tag), 0);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic run_phase(input int unsigned prob, input int max_cyc);
    int n = 0;
    while ((stim.size() != 0 || m_busy(cyc)) && n < max_cyc) begin
      one_cycle(prob);
      n++;
    end
    check("drain_bound", 32'(n < max_cyc), 1);
    repeat (2) one_cycle(prob);
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_addr_a = '0;
    cmd_addr_b = '0;
    cmd_addr_z = '0;
    cmd_tag    = '0;
    cyc        = 0;
    checks     = 0;
    failures   = 0;
    @(negedge clk);
    do_reset(3);

    // Single command latency
    stim.push_back(mk(3, 5, 7, 1));
    run_phase(100, 200);

    // Four independent back-to-back commands
    for (int i = 0; i < 4; i++) stim.push_back(mk(20 + i, 30 + i, 10 + i, i));
    run_phase(100, 200);

    // Read-after-write dependency
    stim.push_back(mk(1, 2, 9, 2));
    stim.push_back(mk(9, 2, 4, 3));
    run_phase(100, 200);

    // Queue fills behind a stalled head
    stim.push_back(mk(1, 2, 50, 0));
    stim.push_back(mk(50, 3, 60, 1));
    for (int i = 0; i < 5; i++) stim.push_back(mk(70 + i, 80 + i, 61 + i, 2 + i));
    run_phase(100, 300);

    // Reset with operations in flight and queued
    stim.push_back(mk(1, 2, 40, 0));
    stim.push_back(mk(3, 4, 41, 1));
    stim.push_back(mk(5, 6, 42, 2));
    stim.push_back(mk(40, 7, 43, 3));
    stim.push_back(mk(8, 9, 44, 4));
    repeat (10) one_cycle(100);
    do_reset(2);
    repeat (40) one_cycle(0);
    stim.push_back(mk(3, 5, 7, 9));
    run_phase(100, 200);

    // Random traffic over a small address space to provoke hazards
    for (int i = 0; i < 120; i++)
      stim.push_back(mk(int'($urandom_range(15)), int'($urandom_range(15)),
                        int'($urandom_range(15)), i % 16));
    run_phase(70, 20000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
